// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}; polarity is applied at the top.
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] code;
        case (nib)
            4'h0:    code = 8'hC0;
            4'h1:    code = 8'hF9;
            4'h2:    code = 8'hA4;
            4'h3:    code = 8'hB0;
            4'h4:    code = 8'h99;
            4'h5:    code = 8'h92;
            4'h6:    code = 8'h82;
            4'h7:    code = 8'hF8;
            4'h8:    code = 8'h80;
            4'h9:    code = 8'h90;
            4'hA:    code = 8'h88;
            4'hB:    code = 8'h83;
            4'hC:    code = 8'hC6;
            4'hD:    code = 8'hA1;
            4'hE:    code = 8'h86;
            default: code = 8'h8E;
        endcase
        return code;
    endfunction

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int unsigned k = 0; k < 32; k++) begin
            if ((64'd1 << width) < 64'(value)) width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble + decimal point -> active-low segment code.
// A suppressed digit shows only its decimal point, if lit.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    input  logic       suppress_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = suppress_i ? SEG_OFF : hex_to_seg(nibble_i);
        if (dp_i) seg_o[7] = 1'b0;
    end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment driver with frame-aligned double-buffered updates.
// Optional feature macro: SEG_DIM_EN (adds brightness port and per-digit duty dimming).
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned SCAN_DIV   = 65536,
    parameter bit          ACTIVE_LOW = 1'b1
)
(
    input  logic                  CLK,
    input  logic                  clr,
`ifdef SEG_DIM_EN
    input  logic [3:0]            brightness,
`endif
    input  logic [4*DIGITS-1:0]   disp_data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    output logic                  load_ack,
    input  logic                  blank,
    input  logic                  lz_en,
    output logic                  frame_start,
    output logic [DIGITS-1:0]     pos_ctrl,
    output logic [7:0]            num_ctrl
);

    localparam int unsigned IW = clog2(DIGITS);
    localparam int unsigned PW = clog2(SCAN_DIV);

    logic [PW-1:0]         prescaler_q, prescaler_d;
    logic [IW-1:0]         index_q, index_d;
    logic [4*DIGITS-1:0]   stage_data_q, stage_data_d;
    logic [DIGITS-1:0]     stage_dp_q, stage_dp_d;
    logic [4*DIGITS-1:0]   shadow_data_q, shadow_data_d;
    logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
    logic                  pending_q, pending_d;
    logic                  load_ack_q, load_ack_d;
    logic                  frame_start_q, frame_start_d;
    logic [DIGITS-1:0]     pos_q, pos_d;
    logic [7:0]            num_q, num_d;

    logic                  scan_tick;
    logic                  boundary;
    logic                  lit;
    logic [DIGITS-1:0]     suppress;
    logic [DIGITS-1:0]     sel;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_sup;
    logic [7:0]            dec_seg;
    logic [7:0]            seg_code;

`ifdef SEG_DIM_EN
    logic [3:0]            bright_q, bright_d;
`endif

    always_comb begin
        scan_tick   = (prescaler_q == PW'(SCAN_DIV - 1));
        boundary    = scan_tick && (index_q == IW'(DIGITS - 1));
        prescaler_d = scan_tick ? '0 : prescaler_q + 1'b1;
        index_d     = index_q;
        if (scan_tick) index_d = (index_q == IW'(DIGITS - 1)) ? '0 : index_q + 1'b1;

        // Staging takes the new load even on the boundary edge; shadow takes the old staging.
        stage_data_d  = load ? disp_data : stage_data_q;
        stage_dp_d    = load ? dp_in : stage_dp_q;
        shadow_data_d = (boundary && pending_q) ? stage_data_q : shadow_data_q;
        shadow_dp_d   = (boundary && pending_q) ? stage_dp_q : shadow_dp_q;
        pending_d     = load ? 1'b1 : (boundary ? 1'b0 : pending_q);
        load_ack_d    = boundary && pending_q;
        frame_start_d = boundary;
    end

    // Digit i is a leading zero when it and every higher nibble are zero.
    always_comb begin
        logic all_zero;
        int unsigned i;
        all_zero = 1'b1;
        suppress = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            i = DIGITS - 1 - k;
            all_zero = all_zero && (shadow_data_q[4*i +: 4] == 4'h0);
            suppress[i] = lz_en && all_zero && (i != 0);
        end
    end

    always_comb begin
        sel     = '0;
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_sup = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (index_q == IW'(k)) begin
                sel[k]  = 1'b1;
                cur_nib = shadow_data_q[4*k +: 4];
                cur_dp  = shadow_dp_q[k];
                cur_sup = suppress[k];
            end
        end
    end

    seg_hex_decoder u_dec (
        .nibble_i   (cur_nib),
        .dp_i       (cur_dp),
        .suppress_i (cur_sup),
        .seg_o      (dec_seg)
    );

`ifdef SEG_DIM_EN
    always_comb begin
        bright_d = scan_tick ? brightness : bright_q;
        lit = (int unsigned'(prescaler_q) < (int unsigned'(bright_q) + 1) * (SCAN_DIV / 16));
    end
`else
    assign lit = 1'b1;
`endif

    always_comb begin
        seg_code = blank ? SEG_OFF : dec_seg;
        num_d    = ACTIVE_LOW ? seg_code : ~seg_code;
        pos_d    = ACTIVE_LOW ? ~(lit ? sel : '0) : (lit ? sel : '0);
    end

    always_ff @(posedge CLK) begin
        if (clr) begin
            prescaler_q   <= '0;
            index_q       <= '0;
            stage_data_q  <= '0;
            stage_dp_q    <= '0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            pending_q     <= 1'b0;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
            pos_q         <= ACTIVE_LOW ? '1 : '0;
            num_q         <= ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
`ifdef SEG_DIM_EN
            bright_q      <= brightness;
`endif
        end else begin
            prescaler_q   <= prescaler_d;
            index_q       <= index_d;
            stage_data_q  <= stage_data_d;
            stage_dp_q    <= stage_dp_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            pending_q     <= pending_d;
            load_ack_q    <= load_ack_d;
            frame_start_q <= frame_start_d;
            pos_q         <= pos_d;
            num_q         <= num_d;
`ifdef SEG_DIM_EN
            bright_q      <= bright_d;
`endif
        end
    end

    assign load_ack    = load_ack_q;
    assign frame_start = frame_start_q;
    assign pos_ctrl    = pos_q;
    assign num_ctrl    = num_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display (DIGITS=4, SCAN_DIV=16, ACTIVE_LOW=1).
module tb_seg_scan_display;

    logic        CLK;
    logic        clr;
    logic [15:0] disp_data;
    logic [3:0]  dp_in;
    logic        load;
    logic        load_ack;
    logic        blank;
    logic        lz_en;
    logic        frame_start;
    logic [3:0]  pos_ctrl;
    logic [7:0]  num_ctrl;
`ifdef SEG_DIM_EN
    logic [3:0]  brightness;
`endif

    int          n_cmp;
    int          n_err;
    int unsigned cyc;
    bit          ack_flag;

    seg_scan_display #(
        .DIGITS     (4),
        .SCAN_DIV   (16),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .CLK         (CLK),
        .clr         (clr),
`ifdef SEG_DIM_EN
        .brightness  (brightness),
`endif
        .disp_data   (disp_data),
        .dp_in       (dp_in),
        .load        (load),
        .load_ack    (load_ack),
        .blank       (blank),
        .lz_en       (lz_en),
        .frame_start (frame_start),
        .pos_ctrl    (pos_ctrl),
        .num_ctrl    (num_ctrl)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // codes = {digit3, digit2, digit1, digit0} expected on num_ctrl
    task automatic step_check(input logic [31:0] codes);
        int unsigned d;
        logic [3:0]  one;
        logic [3:0]  exp_pos;
        logic        fs_exp;
        @(posedge CLK);
        #1;
        cyc++;
        d       = ((cyc - 1) / 16) % 4;
        one     = 4'b0001;
        exp_pos = ~(one << d);
        fs_exp  = (cyc % 64 == 0);
        chk("pos_ctrl", {4'h0, pos_ctrl}, {4'h0, exp_pos});
        chk("num_ctrl", num_ctrl, codes[8*d +: 8]);
        chk("frame_start", {7'h0, frame_start}, {7'h0, fs_exp});
        chk("load_ack", {7'h0, load_ack}, {7'h0, fs_exp && ack_flag});
    endtask

    task automatic run_frame(input logic [31:0] codes, input bit ack_end,
                             input int ld1_at, input logic [15:0] ld1_data, input logic [3:0] ld1_dp,
                             input int ld2_at, input logic [15:0] ld2_data);
        ack_flag = ack_end;
        for (int j = 0; j < 64; j++) begin
            load = 1'b0;
            if (j == ld1_at) begin
                load = 1'b1; disp_data = ld1_data; dp_in = ld1_dp;
            end else if (j == ld2_at) begin
                load = 1'b1; disp_data = ld2_data; dp_in = 4'b0000;
            end
            step_check(codes);
        end
        load = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; ack_flag = 1'b0;
        clr = 1'b1; disp_data = '0; dp_in = '0; load = 1'b0; blank = 1'b0; lz_en = 1'b0;
`ifdef SEG_DIM_EN
        brightness = 4'hF;
`endif
        @(posedge CLK);
        #1;
        chk("rst_pos", {4'h0, pos_ctrl}, 8'h0F);
        chk("rst_num", num_ctrl, 8'hFF);
        chk("rst_ack", {7'h0, load_ack}, 8'h00);
        chk("rst_fs", {7'h0, frame_start}, 8'h00);
        clr = 1'b0;
        cyc = 0;

        // idle frame after reset, then a mid-frame load that must wait for the wrap
        run_frame(32'hC0C0C0C0, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0);
        run_frame(32'hC0C0C0C0, 1'b1, 20, 16'h12AF, 4'h0, -1, 16'h0);
        // 12AF displayed; two loads collapse into one ack
        run_frame(32'hF9A4888E, 1'b1, 5, 16'h1111, 4'h0, 30, 16'h2222);
        lz_en = 1'b1;
        run_frame(32'hA4A4A4A4, 1'b1, 10, 16'h0050, 4'b1000, -1, 16'h0);
        run_frame(32'h7FFF92C0, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0);
        // blanked frame; second load lands on the boundary edge itself
        blank = 1'b1;
        run_frame(32'hFFFFFFFF, 1'b1, 40, 16'h0003, 4'h0, 63, 16'h0004);
        blank = 1'b0;
        run_frame(32'hFFFFFFB0, 1'b1, -1, 16'h0, 4'h0, -1, 16'h0);
        run_frame(32'hFFFFFF99, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0);

        // clr mid-frame with a load pending
        ack_flag = 1'b0;
        for (int j = 0; j < 10; j++) step_check(32'hFFFFFF99);
        load = 1'b1; disp_data = 16'h9999; dp_in = 4'b0000;
        step_check(32'hFFFFFF99);
        load = 1'b0;
        for (int j = 0; j < 19; j++) step_check(32'hFFFFFF99);
        clr = 1'b1;
        @(posedge CLK);
        #1;
        chk("clr_pos", {4'h0, pos_ctrl}, 8'h0F);
        chk("clr_num", num_ctrl, 8'hFF);
        chk("clr_ack", {7'h0, load_ack}, 8'h00);
        clr = 1'b0;
        cyc = 0;
        run_frame(32'hFFFFFFC0, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0);
        run_frame(32'hFFFFFFC0, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
